goomba_stomp_judge: RTL

Consumes the Mario and Goomba positions produced by the movers and decides the outcome of every contact: stomp (Goomba squashed, score awarded) or hit (game lost). It sits between the Goomba mover and the renderer/score display. It owns the Goomba life cycle (alive, squashed, dead, optional respawn) and exposes registered status flags that the renderer and Mario mover read.

---
 rtl/goomba_stomp_judge_pkg.sv | 23 ++
 rtl/goomba_stomp_judge_if.sv | 26 ++
 rtl/goomba_stomp_judge_hitbox_compare.sv | 28 ++
 rtl/goomba_stomp_judge.sv | 131 +++++++++++++
 4 files changed

// File: rtl/goomba_stomp_judge_pkg.sv
// Shared types for the Goomba stomp judge: life-cycle states and tick-counter sizing.
package goomba_pkg;

    typedef enum logic [1:0] {
        ALIVE    = 2'd0,
        SQUASHED = 2'd1,
        DEAD     = 2'd2,
        LOST     = 2'd3
    } goomba_state_t;

    localparam int DEF_SQUASH_TICKS  = 30;
    localparam int DEF_RESPAWN_TICKS = 120;

    // The counter only ever holds a tick budget minus one.
    function automatic int tick_cnt_width(input int squash_ticks, input int respawn_ticks);
        int m;
        m = (squash_ticks > respawn_ticks) ? squash_ticks : respawn_ticks;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int TICK_CNT_W = tick_cnt_width(DEF_SQUASH_TICKS, DEF_RESPAWN_TICKS);

endpackage

// File: rtl/goomba_stomp_judge_if.sv
// Position inputs and status outputs of the stomp judge; master drives positions, slave is the judge.
interface goomba_stomp_judge_if #(
    parameter int SCORE_WIDTH = 16
) ();
    logic                   movement_tick;
    logic signed [31:0]     mario_x;
    logic signed [31:0]     mario_y;
    logic signed [31:0]     goomba_x;
    logic signed [31:0]     goomba_y;
    logic                   mario_falling;
    logic                   goomba_alive;
    logic                   goomba_squashed;
    logic                   stomp;
    logic                   lose;
    logic [SCORE_WIDTH-1:0] score;

    modport master (
        output movement_tick, mario_x, mario_y, goomba_x, goomba_y, mario_falling,
        input  goomba_alive, goomba_squashed, stomp, lose, score
    );

    modport slave (
        input  movement_tick, mario_x, mario_y, goomba_x, goomba_y, mario_falling,
        output goomba_alive, goomba_squashed, stomp, lose, score
    );
endinterface

// File: rtl/goomba_stomp_judge_hitbox_compare.sv
// Combinational hitbox test for one Mario/Goomba pair: overlap and stomp qualification.
module goomba_hitbox_compare #(
    parameter int CHARACTER_WIDTH = 42,
    parameter int STOMP_MARGIN    = 12
) (
    input  logic signed [31:0] i_mario_x,
    input  logic signed [31:0] i_mario_y,
    input  logic signed [31:0] i_goomba_x,
    input  logic signed [31:0] i_goomba_y,
    input  logic               i_mario_falling,
    output logic               o_overlap,
    output logic               o_stomp_ok
);
    localparam logic signed [31:0] L_W      = CHARACTER_WIDTH;
    localparam logic signed [31:0] L_MARGIN = STOMP_MARGIN;

    logic signed [31:0] w_dx;
    logic signed [31:0] w_dy;
    logic signed [31:0] w_depth;

    assign w_dx    = i_mario_x - i_goomba_x;
    assign w_dy    = i_mario_y - i_goomba_y;
    // How far Mario's feet sink below the Goomba's top edge.
    assign w_depth = i_mario_y + L_W - i_goomba_y;

    assign o_overlap  = (w_dx < L_W) && (w_dx > -L_W) && (w_dy < L_W) && (w_dy > -L_W);
    assign o_stomp_ok = o_overlap && i_mario_falling && (w_depth <= L_MARGIN);
endmodule

// File: rtl/goomba_stomp_judge.sv
// Goomba life-cycle and contact judge. Optional respawn out of DEAD when GOOMBA_RESPAWN_EN is defined.
module goomba_stomp_judge
    import goomba_pkg::*;
#(
    parameter int CHARACTER_WIDTH = 42,
    parameter int STOMP_MARGIN    = 12,
    parameter int SQUASH_TICKS    = 30,
    parameter int RESPAWN_TICKS   = 120,
    parameter int STOMP_SCORE     = 100,
    parameter int SCORE_WIDTH     = 16
) (
    input  logic                 vga_clock,
    input  logic                 reset,
    goomba_stomp_judge_if.slave  bus
);
    localparam int CNT_W = tick_cnt_width(SQUASH_TICKS, RESPAWN_TICKS);
    localparam logic [SCORE_WIDTH-1:0] L_SCORE_MAX = '1;

    goomba_state_t          r_state;
    goomba_state_t          w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [SCORE_WIDTH-1:0] r_score;
    logic [SCORE_WIDTH-1:0] w_score_nxt;
    logic                   r_stomp;
    logic                   w_stomp_nxt;
    logic                   w_overlap;
    logic                   w_stomp_ok;
    logic                   w_stomp_evt;
    logic [31:0]            w_sum;

    goomba_hitbox_compare #(
        .CHARACTER_WIDTH (CHARACTER_WIDTH),
        .STOMP_MARGIN    (STOMP_MARGIN)
    ) u_hitbox (
        .i_mario_x       (bus.mario_x),
        .i_mario_y       (bus.mario_y),
        .i_goomba_x      (bus.goomba_x),
        .i_goomba_y      (bus.goomba_y),
        .i_mario_falling (bus.mario_falling),
        .o_overlap       (w_overlap),
        .o_stomp_ok      (w_stomp_ok)
    );

    // State, tick counter, score and stomp pulse registers
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_state <= ALIVE;
            r_cnt   <= '0;
            r_score <= '0;
            r_stomp <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_score <= w_score_nxt;
            r_stomp <= w_stomp_nxt;
        end
    end

    // Next state and counter; stomp geometry takes priority over a hit
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (bus.movement_tick) begin
            case (r_state)
                ALIVE: begin
                    if (w_stomp_ok) begin
                        w_state_nxt = SQUASHED;
                        w_cnt_nxt   = CNT_W'(SQUASH_TICKS - 1);
                    end else if (w_overlap) begin
                        w_state_nxt = LOST;
                    end else begin
                        w_state_nxt = ALIVE;
                    end
                end
                SQUASHED: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = DEAD;
`ifdef GOOMBA_RESPAWN_EN
                        w_cnt_nxt   = CNT_W'(RESPAWN_TICKS - 1);
`else
                        w_cnt_nxt   = '0;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                DEAD: begin
`ifdef GOOMBA_RESPAWN_EN
                    if (r_cnt == '0) begin
                        w_state_nxt = ALIVE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
`else
                    w_state_nxt = DEAD;
`endif
                end
                LOST:    w_state_nxt = LOST;
                default: w_state_nxt = ALIVE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign w_stomp_evt = bus.movement_tick && (r_state == ALIVE) && w_stomp_ok;
    assign w_sum       = 32'(r_score) + 32'(STOMP_SCORE);

    // Stomp pulse and saturating score update
    always_comb begin
        w_score_nxt = r_score;
        w_stomp_nxt = 1'b0;
        if (w_stomp_evt) begin
            w_stomp_nxt = 1'b1;
            if (w_sum > 32'(L_SCORE_MAX)) begin
                w_score_nxt = L_SCORE_MAX;
            end else begin
                w_score_nxt = w_sum[SCORE_WIDTH-1:0];
            end
        end else begin
            w_stomp_nxt = 1'b0;
        end
    end

    assign bus.goomba_alive    = (r_state == ALIVE);
    assign bus.goomba_squashed = (r_state == SQUASHED);
    assign bus.lose            = (r_state == LOST);
    assign bus.stomp           = r_stomp;
    assign bus.score           = r_score;
endmodule
